// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 padder. Takes a 32-bit big-endian word stream and emits 512-bit sha256in_t blocks.
// Defining SHA256_PADDER_LENCHK_EN adds the sticky bit-length overflow flag o_len_err.

package user_type;
    typedef struct packed {
        logic         state;
        logic         start;
        logic         stop;
        logic [511:0] w;
    } sha256in_t;
endpackage

// state     | meaning
// S_FILL    | accepting message words into the block under construction
// S_EMIT    | block presented, more blocks of this message follow
// S_EXTRA   | one cycle building the trailing padding-only block
// S_EMIT_LAST | final block of the message presented
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [31:0]           i_data,
    input  logic                  i_last,
    input  logic [2:0]            i_nbytes,
    output user_type::sha256in_t  o_blk,
    input  logic                  i_blk_rdy
`ifdef SHA256_PADDER_LENCHK_EN
    ,
    output logic                  o_len_err
`endif
);

    typedef enum logic [1:0] {
        S_FILL,
        S_EMIT,
        S_EXTRA,
        S_EMIT_LAST
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    user_type::sha256in_t r_blk;
    logic [3:0]           r_idx;
    logic [LEN_W-1:0]     r_len;
    logic                 r_first;
    logic                 r_extra;
    logic                 r_extra_80;
    logic                 r_rdy_en;

    logic                 w_xfer;
    logic [2:0]           w_n;
    logic [6:0]           w_p;
    logic                 w_single;
    logic [5:0]           w_add;
    logic [LEN_W:0]       w_len_sum;
    logic [63:0]          w_len64;
    logic [63:0]          w_len64_cur;
    logic [511:0]         w_blk;

    assign i_ready     = r_rdy_en & (r_state == S_FILL);
    assign o_blk       = r_blk;
    assign w_xfer      = i_valid & i_ready;
    assign w_n         = (i_nbytes > 3'd4) ? 3'd4 : i_nbytes;
    assign w_p         = {1'b0, r_idx, 2'b00} + {4'b0000, w_n};
    assign w_single    = (w_p <= 7'd55);
    assign w_add       = i_last ? {w_n, 3'b000} : 6'd32;
    assign w_len_sum   = {1'b0, r_len} + {{(LEN_W-5){1'b0}}, w_add};
    assign w_len64     = 64'(w_len_sum[LEN_W-1:0]);
    assign w_len64_cur = 64'(r_len);

    // Block image after the current word: earlier words kept, the 0x80 marker and
    // zero fill applied on the last word, and the length folded in when it fits.
    always_comb begin
        w_blk = r_blk.w;
        for (int b = 0; b < 64; b++) begin
            if ((b / 4) == int'(r_idx)) begin
                if (!i_last || ((b % 4) < int'(w_n))) begin
                    w_blk[511-8*b -: 8] = i_data[31-8*(b%4) -: 8];
                end else if ((b % 4) == int'(w_n)) begin
                    w_blk[511-8*b -: 8] = 8'h80;
                end else begin
                    w_blk[511-8*b -: 8] = 8'h00;
                end
            end else if (((b / 4) > int'(r_idx)) && i_last) begin
                w_blk[511-8*b -: 8] = (b == int'(w_p)) ? 8'h80 : 8'h00;
            end
        end
        if (i_last && w_single) begin
            w_blk[63:0] = w_len64;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_xfer) begin
                    if (i_last) begin
                        w_state_nxt = w_single ? S_EMIT_LAST : S_EMIT;
                    end else if (r_idx == 4'd15) begin
                        w_state_nxt = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (i_blk_rdy) begin
                    w_state_nxt = r_extra ? S_EXTRA : S_FILL;
                end
            end
            S_EXTRA: begin
                w_state_nxt = S_EMIT_LAST;
            end
            S_EMIT_LAST: begin
                if (i_blk_rdy) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk      <= '0;
            r_idx      <= 4'd0;
            r_len      <= '0;
            r_first    <= 1'b1;
            r_extra    <= 1'b0;
            r_extra_80 <= 1'b0;
            r_rdy_en   <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            case (r_state)
                S_FILL: begin
                    if (w_xfer) begin
                        r_blk.w <= w_blk;
                        r_len   <= w_len_sum[LEN_W-1:0];
                        if (i_last) begin
                            r_blk.state <= 1'b1;
                            r_blk.start <= r_first;
                            r_blk.stop  <= w_single;
                            r_extra     <= ~w_single;
                            r_extra_80  <= (w_p == 7'd64);
                            r_idx       <= 4'd0;
                        end else if (r_idx == 4'd15) begin
                            r_blk.state <= 1'b1;
                            r_blk.start <= r_first;
                            r_blk.stop  <= 1'b0;
                            r_extra     <= 1'b0;
                            r_idx       <= 4'd0;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                S_EMIT: begin
                    if (i_blk_rdy) begin
                        r_blk.state <= 1'b0;
                        r_first     <= 1'b0;
                    end
                end
                S_EXTRA: begin
                    r_blk.w     <= {(r_extra_80 ? 8'h80 : 8'h00), 440'd0, w_len64_cur};
                    r_blk.state <= 1'b1;
                    r_blk.start <= r_first;
                    r_blk.stop  <= 1'b1;
                    r_extra     <= 1'b0;
                end
                S_EMIT_LAST: begin
                    if (i_blk_rdy) begin
                        r_blk.state <= 1'b0;
                        r_len       <= '0;
                        r_idx       <= 4'd0;
                        r_first     <= 1'b1;
                        r_extra     <= 1'b0;
                    end
                end
                default: begin
                    r_idx <= 4'd0;
                end
            endcase
        end
    end

`ifdef SHA256_PADDER_LENCHK_EN
    logic r_len_err;

    // The first word of a message clears the flag, unless that word itself carries out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_err <= 1'b0;
        end else if (w_xfer) begin
            r_len_err <= ((r_first && (r_idx == 4'd0)) ? 1'b0 : r_len_err) | w_len_sum[LEN_W];
        end
    end

    assign o_len_err = r_len_err;
`else
    logic w_unused_carry;
    assign w_unused_carry = w_len_sum[LEN_W];
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: drives word streams into sha256_padder and checks blocks against a byte-level FIPS 180-4 padding model.
module tb_sha256_padder;

    logic                 clk;
    logic                 rst_n;
    logic                 i_valid;
    logic                 i_ready;
    logic [31:0]          i_data;
    logic                 i_last;
    logic [2:0]           i_nbytes;
    user_type::sha256in_t o_blk;
    logic                 i_blk_rdy;
`ifdef SHA256_PADDER_LENCHK_EN
    logic                 o_len_err;
`endif

    int tests = 0;
    int fails = 0;

    logic [31:0]  q_words[$];
    logic [514:0] q_exp[$];
    logic [514:0] q_got[$];
    int           g_nw;
    int           g_n;
    int           g_nblk;
    bit           g_extra;
    bit           use_abc;

    sha256_padder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_data    (i_data),
        .i_last    (i_last),
        .i_nbytes  (i_nbytes),
        .o_blk     (o_blk),
        .i_blk_rdy (i_blk_rdy)
`ifdef SHA256_PADDER_LENCHK_EN
        ,
        .o_len_err (o_len_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [514:0] obs, input logic [514:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: message bytes + 0x80 + zeros to 56 mod 64 + 64-bit big-endian bit length.
    task automatic build(input int nw, input int n);
        logic [7:0]   msg[$];
        logic [7:0]   pad[$];
        logic [31:0]  w;
        logic [511:0] blk;
        logic [63:0]  bitlen;
        int           len;
        q_words.delete();
        q_exp.delete();
        q_got.delete();
        len = 4 * (nw - 1) + n;
        for (int i = 0; i < nw; i++) begin
            w = $urandom;
            if (use_abc && i == 0) w = 32'h61626300;
            q_words.push_back(w);
            for (int j = 0; j < 4; j++)
                if (4 * i + j < len) msg.push_back(w[31-8*j -: 8]);
        end
        pad = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bitlen = 64'(len) * 64'd8;
        for (int j = 0; j < 8; j++) pad.push_back(bitlen[63-8*j -: 8]);
        g_nblk = pad.size() / 64;
        for (int bi = 0; bi < g_nblk; bi++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pad[64*bi+j];
            q_exp.push_back({1'b1, (bi == 0), (bi == g_nblk - 1), blk});
        end
        g_extra = (((nw - 1) / 16) == g_nblk - 2);
        g_nw = nw;
        g_n = n;
    endtask

    task automatic drive(input bit gaps);
        bit done;
        int cyc;
        for (int i = 0; i < g_nw; i++) begin
            done = 1'b0;
            cyc = 0;
            while (!done && cyc < 300) begin
                @(negedge clk);
                cyc++;
                if (gaps && $urandom_range(0, 2) == 0) begin
                    i_valid = 1'b0;
                    i_data  = $urandom;
                end else begin
                    i_valid = 1'b1;
                    i_data  = q_words[i];
                    i_last  = (i == g_nw - 1);
                    if (i_last)
                        i_nbytes = (g_n == 4) ? 3'($urandom_range(4, 7)) : 3'(g_n);
                    else
                        i_nbytes = 3'($urandom_range(0, 7));
                end
                done = i_valid && i_ready;
            end
            if (!done) begin
                chk("drv_accept", 515'(done), 515'd1);
                i_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        chk("last_latency", 515'(o_blk.state), 515'd1);
    endtask

    task automatic recv(input int mode);
        int           got = 0;
        int           cyc = 0;
        int           held = 0;
        bit           prev_v = 1'b0;
        bit           expect_v = 1'b0;
        logic [514:0] prev = '0;
        while (got < g_nblk && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (expect_v) begin
                chk("extra_latency", 515'(o_blk.state), 515'd1);
                expect_v = 1'b0;
            end
            if (prev_v) chk("hold_stable", o_blk, prev);
            if (mode == 2 && o_blk.state && held < 10) begin
                i_blk_rdy = 1'b0;
                held++;
                chk("hold_i_ready", 515'(i_ready), 515'd0);
            end else if (mode == 1) begin
                i_blk_rdy = ($urandom_range(0, 2) == 0);
            end else begin
                i_blk_rdy = 1'b1;
            end
            if (o_blk.state) begin
                if (i_blk_rdy) begin
                    q_got.push_back(o_blk);
                    chk("block", o_blk, q_exp[got]);
                    got++;
                    prev_v = 1'b0;
                    if (g_extra && got == g_nblk - 1) begin
                        @(negedge clk);
                        cyc++;
                        i_blk_rdy = 1'b0;
                        chk("extra_gap", 515'(o_blk.state), 515'd0);
                        expect_v = 1'b1;
                    end
                end else begin
                    prev = o_blk;
                    prev_v = 1'b1;
                end
            end else begin
                prev_v = 1'b0;
            end
        end
        if (got < g_nblk) begin
            chk("recv_count", 515'(got), 515'(g_nblk));
        end else begin
            @(negedge clk);
            i_blk_rdy = 1'b0;
            chk("state_drop", 515'(o_blk.state), 515'd0);
        end
        i_blk_rdy = 1'b0;
    endtask

    task automatic run_msg(input int nw, input int n, input bit gaps, input int mode);
        build(nw, n);
        fork
            drive(gaps);
            recv(mode);
        join
    endtask

    initial begin
        bit seen;
        bit ok;
        int cyc;
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_data = '0;
        i_last = 1'b0;
        i_nbytes = '0;
        i_blk_rdy = 1'b0;
        use_abc = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_blk", o_blk, 515'd0);
        chk("reset_i_ready", 515'(i_ready), 515'd0);
`ifdef SHA256_PADDER_LENCHK_EN
        chk("reset_len_err", 515'(o_len_err), 515'd0);
`endif
        rst_n = 1'b1;
        #1 chk("i_ready_at_release", 515'(i_ready), 515'd0);
        @(negedge clk);
        chk("i_ready_after_release", 515'(i_ready), 515'd1);

        use_abc = 1'b1;
        run_msg(1, 3, 1'b0, 0);
        use_abc = 1'b0;
        chk("abc_word0", 515'(q_got[0][511:480]), 515'h61626380);
        chk("abc_len", 515'(q_got[0][63:0]), 515'h18);
        chk("abc_start_stop", 515'(q_got[0][513:512]), 515'b11);

        run_msg(1, 0, 1'b0, 0);
        chk("empty_blk", q_got[0], {3'b111, 32'h80000000, 480'd0});

        run_msg(14, 3, 1'b0, 0);
        chk("b55_len", 515'(q_got[0][63:0]), 515'h1B8);

        run_msg(14, 4, 1'b0, 0);
        chk("b56_first_flags", 515'(q_got[0][513:512]), 515'b10);
        chk("b56_second", q_got[1], {3'b101, 448'd0, 64'h1C0});

        run_msg(16, 4, 1'b0, 0);
        chk("b64_second", q_got[1], {3'b101, 32'h80000000, 416'd0, 64'h200});

        run_msg(17, 0, 1'b1, 1);
        run_msg(16, 0, 1'b1, 1);
        run_msg(3, 2, 1'b0, 2);

        // Abandon a message mid-way with reset.
        build(10, 1);
        for (int i = 0; i < 5; i++) begin
            ok = 1'b0;
            cyc = 0;
            while (!ok && cyc < 100) begin
                @(negedge clk);
                cyc++;
                i_valid = 1'b1;
                i_data = q_words[i];
                i_last = 1'b0;
                ok = i_ready;
            end
            if (!ok) chk("rst_pre_accept", 515'(ok), 515'd1);
        end
        @(negedge clk);
        i_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk("midrst_blk", o_blk, 515'd0);
        chk("midrst_i_ready", 515'(i_ready), 515'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_blk.state) seen = 1'b1;
        end
        chk("midrst_no_output", 515'(seen), 515'd0);
        run_msg(2, 1, 1'b0, 0);

        for (int r = 0; r < 25; r++) begin
            run_msg($urandom_range(1, 40), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
